// File: rtl/idx_onehot_dispatcher.sv
// Receive end of the priority-encoded request path: buffers incoming indices in a
// small FIFO and replays each as a one-hot pulse held HOLD_CYCLES cycles, then one idle cycle.
module idx_onehot_dispatcher #(
    parameter  int IDX_W       = 2,
    parameter  int DEPTH       = 4,
    parameter  int HOLD_CYCLES = 2,
    localparam int N           = 2 ** IDX_W,
    localparam int LVL_W       = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IDX_W-1:0] in_idx,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             flush,
    output logic [N-1:0]     out_onehot,
    output logic             out_valid,
    output logic [LVL_W-1:0] level,
    output logic [1:0]       dbg_state_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRIVE = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [N-1:0]       onehot_q, onehot_d;
    logic               valid_q, valid_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]   level_q, level_d;
    logic [IDX_W-1:0]   mem_q [DEPTH];
    logic               push, pop;

    // Readiness comes only from registered occupancy; a same-cycle pop never frees a slot.
    assign in_ready = (level_q != LVL_W'(DEPTH));
    assign push     = in_valid && in_ready && !flush;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        onehot_d = onehot_q;
        pop      = 1'b0;
        if (flush) begin
            state_d  = S_IDLE;
            cnt_d    = '0;
            onehot_d = '0;
        end else begin
            case (state_q)
                S_IDLE, S_GAP: begin
                    if (level_q != '0) begin
                        pop      = 1'b1;
                        onehot_d = N'(1) << mem_q[rd_ptr_q];
                        cnt_d    = CNT_W'(HOLD_CYCLES - 1);
                        state_d  = S_DRIVE;
                    end else begin
                        onehot_d = '0;
                        state_d  = S_IDLE;
                    end
                end
                S_DRIVE: begin
                    if (cnt_q == '0) begin
                        onehot_d = '0;
                        state_d  = S_GAP;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                default: begin
                    onehot_d = '0;
                    state_d  = S_IDLE;
                end
            endcase
        end
        valid_d = (onehot_d != '0);
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   level_d = level_q + LVL_W'(1);
                2'b01:   level_d = level_q - LVL_W'(1);
                default: level_d = level_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            onehot_q <= '0;
            valid_q  <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            onehot_q <= onehot_d;
            valid_q  <= valid_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage needs no reset: an entry is only read after it has been written.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= in_idx;
    end

    assign out_onehot  = onehot_q;
    assign out_valid   = valid_q;
    assign level       = level_q;
    assign dbg_state_o = state_q;

endmodule
